fb_read_arbiter: RTL
====================

// Module: fb_read_arbiter
// PURPOSE
//  Shares the single read port of the current-frame framebuffer between two requesters:
//   - the driver (requester 0, streaming, normally wins);
//   - the animator (requester 1, read-modify-write of channel values).
//  Replaces the address-OR of the two requesters with a per-cycle grant.
//  Tags each accepted read and routes the returned data to the requester that issued it.
// PARAMETERS
//  c_ledboards  30  LED boards; channels = c_ledboards*32, c_addr_w = $clog2(channels)
//  c_bpc        12  bits per channel (read data width)
//  c_rd_lat     1   framebuffer read latency in cycles, >=1 (raddr sampled -> rdata valid)
//  c_max_wait   4   consecutive denied cycles for the animator before it is force-granted, >=1
// PORTS
//  i_clk       in   1         system clock (divided clock domain)
//  i_rst       in   1         synchronous reset, active-high
//  i_req0      in   1         driver read request
//  i_addr0     in   c_addr_w  driver read address
//  o_gnt0      out  1         driver request accepted this cycle
//  o_rvalid0   out  1         o_rdata belongs to driver this cycle
//  i_req1      in   1         animator read request
//  i_addr1     in   c_addr_w  animator read address
//  o_gnt1      out  1         animator request accepted this cycle
//  o_rvalid1   out  1         o_rdata belongs to animator this cycle
//  o_rdata     out  c_bpc     read data (pass-through of i_fb_rdata)
//  o_fb_raddr  out  c_addr_w  framebuffer read address
//  i_fb_rdata  in   c_bpc     framebuffer read data
// BEHAVIOUR
//  Reset: o_gnt0/1=0, o_rvalid0/1=0, o_fb_raddr=0, wait_cnt=0, state=PRI_DRV, tag pipe cleared.
//  Handshake:
//   - A requester holds req and addr stable until it sees gnt in the same cycle.
//   - A request is consumed in that cycle; the requester drops req or presents its next address.
//  Grant logic is combinational from req and registered state:
//   - At most one gnt per cycle.
//   - No gnt without the corresponding req.
//   - No gnt while i_rst is high.
//  o_fb_raddr is combinational: the granted requester's address; 0 when nothing is granted.
//  Return path:
//   - Each grant pushes {valid, id} into a c_rd_lat-deep shift pipe.
//   - At the pipe output, o_rvalid<id>=1 exactly c_rd_lat cycles after the grant cycle.
//   - o_rdata = i_fb_rdata at all times; only the rvalid lines qualify it.
//  FSM (registered):
//   - PRI_DRV:
//     - req0 -> gnt0. Else req1 -> gnt1.
//     - Each cycle req1 is high and gnt1 is low, wait_cnt increments, saturating at c_max_wait.
//     - wait_cnt == c_max_wait -> BOOST next cycle.
//   - BOOST:
//     - gnt1 unconditionally (req1 is necessarily high).
//     - wait_cnt cleared; -> PRI_DRV next cycle.
//   - wait_cnt clears whenever gnt1=1 or req1=0.
//  Boundary cases:
//   - Simultaneous req0 and req1 in PRI_DRV: driver wins.
//   - Continuous contention: exactly 1 animator grant per c_max_wait+1 cycles.
//   - req1 dropped while in BOOST: not legal (req is held to grant); the bench asserts against it.
//   - Back-to-back grants to alternating ids: returns stay in issue order with no bubbles.
//   - Reset mid-transfer: in-flight tags are discarded, so no rvalid pulses for pre-reset grants.
//   - Address wrap: none; addresses are passed through unchecked.
// STRUCTURE
//  lamp_pkg.vh (shared include):
//   - localparams c_id_drv=0, c_id_anim=1;
//   - c_fb_rd_lat=1;
//   - function for c_addr_w from c_ledboards.
//  Sub-module rd_tag_pipe:
//   - parameterised depth (c_rd_lat) and width (1+1 bits valid+id);
//   - synchronous clear on i_rst.
//  Top level holds the grant combinational logic, the FSM and wait_cnt.
// TESTING
//  1 Reset: i_rst=1 for 3 cycles with req0=req1=1
//    -> gnt0=gnt1=0, o_fb_raddr=0, no rvalid for 3 cycles after release.
//  2 Driver only, addrs 0..959 on consecutive cycles, fb model rdata=addr
//    -> gnt0 every cycle; o_rvalid0 at cycle+1 with o_rdata=addr; o_rvalid1 never.
//  3 Animator only, addr 0x1A5
//    -> gnt1 same cycle, o_fb_raddr=0x1A5, o_rvalid1 next cycle with rdata=0x1A5.
//  4 Both requesting continuously, c_max_wait=4
//    -> grants repeat as 0,0,0,0,1; each animator gnt1 is exactly 5 cycles apart.
//  5 Alternating single grants with c_rd_lat=3 (0@t, 1@t+1, 0@t+2)
//    -> rvalid0@t+3, rvalid1@t+4, rvalid0@t+5, data matching each address.
//  6 i_rst asserted the cycle after gnt0 (c_rd_lat=2)
//    -> no o_rvalid0 for that read; state=PRI_DRV and wait_cnt=0 after release.

Source files
------------

// File: rtl/fb_read_arbiter_pkg.sv
// Shared types and constants for the framebuffer read-port arbiter.
// Requester ids, default read latency, address-width helper and FSM/tag types.
package fb_read_arbiter_pkg;

  localparam logic c_id_drv  = 1'b0;
  localparam logic c_id_anim = 1'b1;

  localparam int c_fb_rd_lat = 1;

  // One channel per LED on each of 32-channel boards.
  function automatic int fb_addr_w(input int ledboards);
    return $clog2(ledboards * 32);
  endfunction

  typedef enum logic {
    PRI_DRV,
    BOOST
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/fb_read_arbiter_if.sv
// Request/grant/return bundle between the two requesters, the framebuffer and the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface fb_read_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int BPC    = 12
) ();

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              rvalid0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [BPC-1:0]    rdata;
  logic [ADDR_W-1:0] fb_raddr;
  logic [BPC-1:0]    fb_rdata;

  modport slave (
    input  req0, addr0, req1, addr1, fb_rdata,
    output gnt0, rvalid0, gnt1, rvalid1, rdata, fb_raddr
  );

  modport master (
    output req0, addr0, req1, addr1, fb_rdata,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata, fb_raddr
  );

endinterface

// File: rtl/fb_read_arbiter_rd_tag_pipe.sv
// Fixed-depth shift pipe carrying {valid,id} tags alongside the framebuffer read latency.
// Synchronous clear drops every in-flight tag.
module fb_read_arbiter_rd_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] tag_i,
  output logic [WIDTH-1:0] tag_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fb_read_arbiter.sv
// Per-cycle arbiter for the framebuffer read port: driver has priority, the animator is
// force-granted after c_max_wait consecutive denials; returns are routed by tag.
module fb_read_arbiter
  import fb_read_arbiter_pkg::*;
#(
  parameter int c_ledboards = 30,
  parameter int c_bpc       = 12,
  parameter int c_rd_lat    = c_fb_rd_lat,
  parameter int c_max_wait  = 4
) (
  input logic i_clk,
  input logic i_rst,
  fb_read_arbiter_if.slave bus
);

  localparam int c_addr_w = fb_addr_w(c_ledboards);
  localparam int c_wait_w = $clog2(c_max_wait + 1);
  localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(c_max_wait);

  arb_state_e          state_q, state_d;
  logic [c_wait_w-1:0] wait_q, wait_d;
  logic                gnt0, gnt1;
  logic [c_addr_w-1:0] raddr;
  logic [c_bpc-1:0]    rdata;
  rd_tag_t             tag_in, tag_out;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= PRI_DRV;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // The BOOST decision uses the updated count so contention yields one animator grant per c_max_wait+1 cycles.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (gnt1 || !bus.req1) begin
      wait_d = '0;
    end else if (wait_q < c_wait_max) begin
      wait_d = wait_q + c_wait_w'(1);
    end
    case (state_q)
      PRI_DRV: if (wait_d == c_wait_max) state_d = BOOST;
      BOOST:   state_d = PRI_DRV;
      default: state_d = PRI_DRV;
    endcase
  end

  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    raddr = '0;
    if (!i_rst) begin
      case (state_q)
        PRI_DRV: begin
          if (bus.req0) begin
            gnt0 = 1'b1;
          end else if (bus.req1) begin
            gnt1 = 1'b1;
          end
        end
        BOOST:   gnt1 = bus.req1;
        default: gnt0 = 1'b0;
      endcase
    end
    if (gnt0) begin
      raddr = bus.addr0;
    end else if (gnt1) begin
      raddr = bus.addr1;
    end
  end

  assign tag_in.valid = gnt0 | gnt1;
  assign tag_in.id    = gnt1 ? c_id_anim : c_id_drv;

  fb_read_arbiter_rd_tag_pipe #(
    .DEPTH (c_rd_lat),
    .WIDTH ($bits(rd_tag_t))
  ) u_tag_pipe (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign rdata        = bus.fb_rdata;
  assign bus.rdata    = rdata;
  assign bus.fb_raddr = raddr;
  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  // A tag emerging during reset belongs to a discarded transfer.
  assign bus.rvalid0  = tag_out.valid & ~i_rst & (tag_out.id == c_id_drv);
  assign bus.rvalid1  = tag_out.valid & ~i_rst & (tag_out.id == c_id_anim);

endmodule
